// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: default address width, reset PC default, prefetch entry layout {fault, pc, ins}.
package fetch_pkg;

  localparam int unsigned FETCH_RV    = 32;
  localparam int unsigned FETCH_DEPTH = 4;
  localparam logic [FETCH_RV-1:0] RESET_PC_DEF = '0;

  // One buffered parcel. The PC travels with the parcel so execute sees the
  // address of every instruction halfword without recomputing it.
  typedef struct packed {
    logic                fault;
    logic [FETCH_RV-1:0] pc;
    logic [15:0]         ins;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Bundles the decode-side and memory-side signals of the fetch unit.
// Latency: n/a (wires only).
// Backpressure: stall from decode, single outstanding req/ack toward memory.
// Ports: stall, redirect, redirect_pc, ins, ins_pc, ins_fault, idone,
//        ifetch_req, ifetch_addr, ifetch_ack, ifetch_data, ifetch_fault.
interface fetch_if #(
  parameter int unsigned RV = 32
);

  // decode / execute side
  logic          stall;
  logic          redirect;
  logic [RV-1:0] redirect_pc;
  logic [15:0]   ins;
  logic [RV-1:0] ins_pc;
  logic          ins_fault;
  logic          idone;

  // instruction memory side
  logic          ifetch_req;
  logic [RV-1:0] ifetch_addr;
  logic          ifetch_ack;
  logic [15:0]   ifetch_data;
  logic          ifetch_fault;

  // master: the fetch unit itself
  modport master (
    input  stall, redirect, redirect_pc, ifetch_ack, ifetch_data, ifetch_fault,
    output ins, ins_pc, ins_fault, idone, ifetch_req, ifetch_addr
  );

  // slave: decode plus instruction memory surrounding the fetch unit
  modport slave (
    output stall, redirect, redirect_pc, ifetch_ack, ifetch_data, ifetch_fault,
    input  ins, ins_pc, ins_fault, idone, ifetch_req, ifetch_addr
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch parcel buffer: DEPTH x WIDTH circular FIFO with flush.
// Latency: push visible at head the cycle after the push edge; head is combinational read.
// Backpressure: push ignored when full, pop ignored when empty; flush wins over both.
// Ports: clk, reset, flush, push_vld/push_dat, pop_vld, head_dat, count, empty, full.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push_vld,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop_vld,
  output logic [WIDTH-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // and count is a plain subtraction (DEPTH is a power of two).
  assign count    = wr_ptr - rd_ptr;
  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign head_dat = mem[rd_ptr[AW-1:0]];

  assign wr_en = push_vld & ~full  & ~flush;
  assign rd_en = pop_vld  & ~empty & ~flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read once the pointers say valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/fetch.sv
// Instruction fetch front end: single-outstanding halfword reads into a prefetch FIFO, parcels out to decode.
// Latency: req one cycle after IDLE with room; parcel to decode earliest the cycle after ack; redirect -> req next cycle.
// Backpressure: stall holds the FIFO head; requests stop while FIFO is full or after a fetch fault until redirect.
// Ports: clk, reset (async, active-high), bus (fetch_if.master: decode handshake + instruction memory port).
module fetch
  import fetch_pkg::*;
#(
  parameter int unsigned   RV       = FETCH_RV,
  parameter int unsigned   DEPTH    = FETCH_DEPTH,
  parameter logic [RV-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic     clk,
  input  logic     reset,
  fetch_if.master  bus
);

  localparam int unsigned   CW      = $clog2(DEPTH) + 1;
  localparam logic [RV-1:0] HW_MASK = {{(RV-1){1'b1}}, 1'b0};
  localparam logic [RV-1:0] PC_STEP = RV'(2);

  // Request FSM: discard and halted are orthogonal flags, not states.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  logic [0:0]    state_q;
  logic [RV-1:0] addr_q;
  logic [RV-1:0] fetch_pc_q;
  logic          discard_q;
  logic          halted_q;

  logic          ack_vld;
  logic          ack_keep;
  logic          start_req;
  logic          push_vld;
  fetch_entry_t  push_dat;
  fetch_entry_t  head_dat;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_full;

  // A response only counts while a request is actually outstanding; strays
  // (e.g. an ack that lands after reset killed the request) fall through.
  assign ack_vld = (state_q == ST_REQ) & bus.ifetch_ack;

  // Responses landing on a redirect, or answering a pre-redirect request,
  // belong to the old instruction stream and are dropped.
  assign ack_keep = ack_vld & ~discard_q & ~bus.redirect;
  assign push_vld = ack_keep & ~fifo_full;

  assign push_dat.fault = bus.ifetch_fault;
  assign push_dat.pc    = addr_q;
  assign push_dat.ins   = bus.ifetch_data;

  // No request is launched in a redirect cycle: fetch_pc still holds the old
  // stream there, so the new target goes out one cycle later. The count check
  // is sufficient because at most one request is ever in flight.
  assign start_req = (state_q == ST_IDLE) & ~halted_q & ~bus.redirect &
                     (fifo_count < CW'(DEPTH));

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (bus.redirect),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop_vld  (bus.idone),
    .head_dat (head_dat),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      fetch_pc_q <= RESET_PC & HW_MASK;
      discard_q  <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_req) begin
            state_q <= ST_REQ;
            addr_q  <= fetch_pc_q;
          end
        end
        ST_REQ: begin
          // Request drops for at least one cycle after every ack.
          if (bus.ifetch_ack) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase

      if (bus.redirect) begin
        fetch_pc_q <= bus.redirect_pc & HW_MASK;
        halted_q   <= 1'b0;
        // A request still waiting for its ack must have that ack thrown away;
        // an ack arriving right now is already dropped by ack_keep.
        discard_q  <= (state_q == ST_REQ) & ~bus.ifetch_ack;
      end else if (ack_vld) begin
        if (discard_q) begin
          discard_q <= 1'b0;
        end else begin
          // fetch_pc equals addr_q here: it only moves on acks or redirects.
          fetch_pc_q <= fetch_pc_q + PC_STEP;
          if (bus.ifetch_fault) halted_q <= 1'b1;
        end
      end
    end
  end

  assign bus.ifetch_req  = (state_q == ST_REQ);
  assign bus.ifetch_addr = addr_q;

  assign bus.idone     = ~fifo_empty & ~bus.stall & ~bus.redirect;
  assign bus.ins       = head_dat.ins;
  assign bus.ins_pc    = head_dat.pc;
  assign bus.ins_fault = head_dat.fault;

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: in-order delivery, stall buffering, redirects, fault halt, PC wrap, async reset.
// Latency: n/a.
// Backpressure: bench plays decode (stall/redirect) and the instruction memory (ack/data/fault).
module tb_fetch;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  fetch_if #(.RV(32)) bus ();

  fetch #(
    .RV       (32),
    .DEPTH    (4),
    .RESET_PC (32'h100)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a request, check its address, ack it after 'delay'
  // cycles with the given data/fault. Returns one cycle after the ack edge.
  task automatic serve(input string tag, input logic [31:0] exp_addr,
                       input logic [15:0] d, input logic f, input int delay);
    int n = 0;
    while (bus.ifetch_req !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk1({tag, "_req"}, bus.ifetch_req, 1'b1);
    chk32({tag, "_addr"}, bus.ifetch_addr, exp_addr);
    repeat (delay) tick();
    bus.ifetch_ack   = 1'b1;
    bus.ifetch_data  = d;
    bus.ifetch_fault = f;
    tick();
    bus.ifetch_ack   = 1'b0;
    bus.ifetch_data  = '0;
    bus.ifetch_fault = 1'b0;
    #1;
  endtask

  initial begin
    int seen;
    checks = 0;
    errors = 0;
    reset            = 1'b1;
    bus.stall        = 1'b0;
    bus.redirect     = 1'b0;
    bus.redirect_pc  = '0;
    bus.ifetch_ack   = 1'b0;
    bus.ifetch_data  = '0;
    bus.ifetch_fault = 1'b0;

    // Reset state
    repeat (3) tick();
    chk1("rst_req", bus.ifetch_req, 1'b0);
    chk1("rst_idone", bus.idone, 1'b0);
    reset = 1'b0;
    #1;
    chk1("rst_rel_req", bus.ifetch_req, 1'b0);

    // 1: in-order delivery 0x100, 0x102, 0x104
    for (int i = 0; i < 3; i++) begin
      serve("t1", 32'(32'h100 + 2 * i), 16'(16'hA000 + i), 1'b0, 0);
      chk1("t1_idone", bus.idone, 1'b1);
      chk32("t1_pc", bus.ins_pc, 32'(32'h100 + 2 * i));
      chk32("t1_ins", {16'h0, bus.ins}, 32'(32'hA000 + i));
      chk1("t1_fault", bus.ins_fault, 1'b0);
      chk1("t1_req_gap", bus.ifetch_req, 1'b0);
      tick();
    end

    // 2: stall fills exactly 4 entries, then request stops
    bus.stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      serve("t2", 32'(32'h106 + 2 * i), 16'(16'hB000 + i), 1'b0, 0);
      chk1("t2_idone_stalled", bus.idone, 1'b0);
    end
    seen = 0;
    repeat (20) begin
      tick();
      if (bus.ifetch_req || bus.idone) seen++;
    end
    chk32("t2_hold_quiet", 32'(seen), 32'd0);
    bus.stall = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk1("t2_pop_idone", bus.idone, 1'b1);
      chk32("t2_pop_pc", bus.ins_pc, 32'(32'h106 + 2 * i));
      chk32("t2_pop_ins", {16'h0, bus.ins}, 32'(32'hB000 + i));
      tick();
    end
    chk1("t2_drained", bus.idone, 1'b0);

    // 3: redirect to 0x2001 with request 0x10E outstanding, ack 3 cycles later
    chk1("t3_out_req", bus.ifetch_req, 1'b1);
    chk32("t3_out_addr", bus.ifetch_addr, 32'h10E);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h2001;
    #1;
    chk1("t3_redir_idone", bus.idone, 1'b0);
    tick();
    bus.redirect = 1'b0;
    #1;
    chk1("t3_held_req", bus.ifetch_req, 1'b1);
    chk32("t3_held_addr", bus.ifetch_addr, 32'h10E);
    tick();
    tick();
    bus.ifetch_ack  = 1'b1;
    bus.ifetch_data = 16'hDEAD;
    tick();
    bus.ifetch_ack  = 1'b0;
    bus.ifetch_data = '0;
    #1;
    chk1("t3_dropped_idone", bus.idone, 1'b0);
    chk1("t3_gap_req", bus.ifetch_req, 1'b0);
    tick();
    chk1("t3_new_req", bus.ifetch_req, 1'b1);
    chk32("t3_new_addr", bus.ifetch_addr, 32'h2000);
    serve("t3", 32'h2000, 16'hC000, 1'b0, 0);
    chk1("t3_idone", bus.idone, 1'b1);
    chk32("t3_pc", bus.ins_pc, 32'h2000);
    chk32("t3_ins", {16'h0, bus.ins}, 32'h0000C000);

    // 4: redirect coinciding with ack, FIFO holding one parcel
    tick();
    bus.stall = 1'b1;
    serve("t4a", 32'h2002, 16'hC002, 1'b0, 0);
    chk1("t4_stalled_idone", bus.idone, 1'b0);
    tick();
    chk1("t4_req", bus.ifetch_req, 1'b1);
    chk32("t4_addr", bus.ifetch_addr, 32'h2004);
    bus.ifetch_ack  = 1'b1;
    bus.ifetch_data = 16'hBEEF;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h3000;
    bus.stall       = 1'b0;
    #1;
    chk1("t4_redir_idone", bus.idone, 1'b0);
    tick();
    bus.ifetch_ack  = 1'b0;
    bus.ifetch_data = '0;
    bus.redirect    = 1'b0;
    #1;
    chk1("t4_flushed_idone", bus.idone, 1'b0);
    chk1("t4_gap_req", bus.ifetch_req, 1'b0);
    tick();
    chk1("t4_new_req", bus.ifetch_req, 1'b1);
    chk32("t4_new_addr", bus.ifetch_addr, 32'h3000);
    serve("t4b", 32'h3000, 16'hD000, 1'b0, 1);
    chk1("t4_idone", bus.idone, 1'b1);
    chk32("t4_pc", bus.ins_pc, 32'h3000);
    chk32("t4_ins", {16'h0, bus.ins}, 32'h0000D000);

    // 5: fault at 0x300 halts fetch until the next redirect
    tick();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h300;
    tick();
    bus.redirect = 1'b0;
    serve("t5d", 32'h3002, 16'hDEAD, 1'b0, 0);
    chk1("t5d_idone", bus.idone, 1'b0);
    serve("t5", 32'h300, 16'hE000, 1'b1, 0);
    chk1("t5_idone", bus.idone, 1'b1);
    chk32("t5_pc", bus.ins_pc, 32'h300);
    chk1("t5_fault", bus.ins_fault, 1'b1);
    chk32("t5_ins", {16'h0, bus.ins}, 32'h0000E000);
    seen = 0;
    repeat (10) begin
      tick();
      if (bus.ifetch_req) seen++;
    end
    chk32("t5_halted_reqs", 32'(seen), 32'd0);
    chk1("t5_after_idone", bus.idone, 1'b0);

    // 6: PC wrap at the top of the address space, then async reset mid-request
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFE;
    tick();
    bus.redirect = 1'b0;
    #1;
    chk1("t6_redir_next_req", bus.ifetch_req, 1'b0);
    tick();
    chk1("t6_req", bus.ifetch_req, 1'b1);
    chk32("t6_addr", bus.ifetch_addr, 32'hFFFF_FFFE);
    serve("t6", 32'hFFFF_FFFE, 16'hF000, 1'b0, 0);
    chk1("t6_idone", bus.idone, 1'b1);
    chk32("t6_pc", bus.ins_pc, 32'hFFFF_FFFE);
    tick();
    chk1("t6_wrap_req", bus.ifetch_req, 1'b1);
    chk32("t6_wrap_addr", bus.ifetch_addr, 32'h0);
    #1;
    reset = 1'b1;
    #1;
    chk1("t6_rst_req", bus.ifetch_req, 1'b0);
    chk1("t6_rst_idone", bus.idone, 1'b0);
    tick();
    tick();
    reset          = 1'b0;
    bus.ifetch_ack = 1'b1;
    #1;
    chk1("t6_stray_req", bus.ifetch_req, 1'b0);
    tick();
    bus.ifetch_ack = 1'b0;
    #1;
    chk1("t6_post_req", bus.ifetch_req, 1'b1);
    chk32("t6_post_addr", bus.ifetch_addr, 32'h100);
    chk1("t6_stray_idone", bus.idone, 1'b0);
    serve("t6r", 32'h100, 16'h1234, 1'b0, 0);
    chk1("t6r_idone", bus.idone, 1'b1);
    chk32("t6r_pc", bus.ins_pc, 32'h100);
    chk32("t6r_ins", {16'h0, bus.ins}, 32'h00001234);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
